fpu_issue_ctrl: RTL and testbench

Sequential issue/complete wrapper around the combinational single-precision FPU in the accelerator CPU core. It accepts one FP operation at a time over a valid/ready handshake and registers the operands and SELECT code that drive the FPU. It waits a per-class settle latency so the long combinational paths (divide, fused multiply-add) meet timing, then captures the FPU result into a held output with a valid/ready handshake toward writeback.

---
 rtl/fpu_issue_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequential issue/complete wrapper around a combinational FPU.
//
// Accepts one FP operation at a time (valid/ready). It registers the operands and the select
// code that drive the FPU, then waits a per-class settle latency. After that it captures
// the FPU result into a held output with a valid/ready handshake toward writeback.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync abort)
//   in_valid_i / in_ready_o, in_select_i, in_data{1,2,3}_i, in_rd_i : request side
//   fpu_select_o, fpu_data{1,2,3}_o, fpu_result_i                  : FPU side
//   out_valid_o / out_ready_i, out_result_o, out_rd_o, out_illegal_o : result side
//   busy_o : block is not idle
module fpu_issue_ctrl #(
    parameter int unsigned LatFast = 1,
    parameter int unsigned LatAdd  = 2,
    parameter int unsigned LatMul  = 3,
    parameter int unsigned LatDiv  = 6,
    parameter int unsigned LatFma  = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_select_i,
    input  logic [31:0] in_data1_i,
    input  logic [31:0] in_data2_i,
    input  logic [31:0] in_data3_i,
    input  logic [4:0]  in_rd_i,
    output logic [4:0]  fpu_select_o,
    output logic [31:0] fpu_data1_o,
    output logic [31:0] fpu_data2_o,
    output logic [31:0] fpu_data3_o,
    input  logic [31:0] fpu_result_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_result_o,
    output logic [4:0]  out_rd_o,
    output logic        out_illegal_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  fsel_q;
    logic [31:0] fd1_q, fd2_q, fd3_q;
    logic [4:0]  rd_q;
    logic        ill_q;
    logic [31:0] out_res_q;
    logic [4:0]  out_rd_q;
    logic        out_ill_q;

    logic        accept;
    logic        capture;
    logic        in_illegal;
    logic [3:0]  in_lat;

    // Settle latency and legality of the incoming op.
    always_comb begin
        in_illegal = 1'b0;
        in_lat     = 4'(LatFast);
        if (in_select_i == 5'b01101 || in_select_i >= 5'b10011) begin
            in_illegal = 1'b1;
            in_lat     = 4'd1;
        end else begin
            case (in_select_i)
                5'b00001, 5'b00010:                         in_lat = 4'(LatAdd);
                5'b00011:                                   in_lat = 4'(LatMul);
                5'b00100:                                   in_lat = 4'(LatDiv);
                5'b01110, 5'b01111, 5'b10000, 5'b10001:     in_lat = 4'(LatFma);
                default:                                    in_lat = 4'(LatFast);
            endcase
        end
    end

    assign in_ready_o = !flush_i &&
                        (state_q == StIdle || (state_q == StDone && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;
        if (flush_i) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            cnt_d       = 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = StExec;
                        cnt_d   = in_lat - 4'd1;
                    end
                end
                StExec: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        capture     = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        if (accept) begin
                            state_d = StExec;
                            cnt_d   = in_lat - 4'd1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    cnt_d       = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FPU operand registers only move on acceptance so the FPU inputs never glitch mid-op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsel_q <= 5'd0;
            fd1_q  <= 32'd0;
            fd2_q  <= 32'd0;
            fd3_q  <= 32'd0;
            rd_q   <= 5'd0;
            ill_q  <= 1'b0;
        end else if (accept) begin
            fsel_q <= in_select_i;
            fd1_q  <= in_data1_i;
            fd2_q  <= in_data2_i;
            fd3_q  <= in_data3_i;
            rd_q   <= in_rd_i;
            ill_q  <= in_illegal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_res_q <= 32'd0;
            out_rd_q  <= 5'd0;
            out_ill_q <= 1'b0;
        end else if (capture) begin
            out_res_q <= ill_q ? 32'd0 : fpu_result_i;
            out_rd_q  <= rd_q;
            out_ill_q <= ill_q;
        end
    end

    assign fpu_select_o  = fsel_q;
    assign fpu_data1_o   = fd1_q;
    assign fpu_data2_o   = fd2_q;
    assign fpu_data3_o   = fd3_q;
    assign out_valid_o   = out_valid_q;
    assign out_result_o  = out_res_q;
    assign out_rd_o      = out_rd_q;
    assign out_illegal_o = out_ill_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model (in-flight countdown + held result).
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [4:0]  in_select, in_rd, fpu_select, out_rd;
    logic [31:0] in_data1, in_data2, in_data3;
    logic [31:0] fpu_data1, fpu_data2, fpu_data3, fpu_result, out_result;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_select_i   (in_select),
        .in_data1_i    (in_data1),
        .in_data2_i    (in_data2),
        .in_data3_i    (in_data3),
        .in_rd_i       (in_rd),
        .fpu_select_o  (fpu_select),
        .fpu_data1_o   (fpu_data1),
        .fpu_data2_o   (fpu_data2),
        .fpu_data3_o   (fpu_data3),
        .fpu_result_i  (fpu_result),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_result_o  (out_result),
        .out_rd_o      (out_rd),
        .out_illegal_o (out_illegal),
        .busy_o        (busy)
    );

    // Stand-in FPU: real IEEE answers for the directed cases, an operand hash otherwise.
    function automatic logic [31:0] fpu_fn(logic [4:0] s, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] c);
        if (s == 5'd1 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s == 5'd2 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (s == 5'd3 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (s == 5'd4 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (s == 5'd10 && a == b) return 32'h00000001;
        return a ^ {b[15:0], b[31:16]} ^ (c + 32'h9E3779B9) ^ {27'd0, s};
    endfunction

    assign fpu_result = fpu_fn(fpu_select, fpu_data1, fpu_data2, fpu_data3);

    function automatic bit is_illegal(logic [4:0] s);
        return (s == 5'd13) || (s >= 5'd19);
    endfunction

    function automatic int lat_of(logic [4:0] s);
        if (is_illegal(s)) return 1;
        if (s == 5'd1 || s == 5'd2) return 2;
        if (s == 5'd3) return 3;
        if (s == 5'd4) return 6;
        if (s >= 5'd14 && s <= 5'd17) return 5;
        return 1;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: cycles left for the op in flight, and whether a result is held.
    int          m_left;
    bit          m_hold, m_ill, m_pill, last_acc;
    logic [31:0] m_res, m_fd1, m_fd2, m_fd3;
    logic [4:0]  m_rd, m_fsel, m_tag;

    task automatic model_reset();
        m_left = 0; m_hold = 0; m_ill = 0; m_pill = 0;
        m_res = '0; m_fd1 = '0; m_fd2 = '0; m_fd3 = '0;
        m_rd = '0; m_fsel = '0; m_tag = '0;
    endtask

    function automatic bit m_in_ready();
        return !flush && m_left == 0 && (!m_hold || out_ready);
    endfunction

    task automatic model_update();
        bit acc;
        last_acc = 0;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_left = 0;
            m_hold = 0;
        end else begin
            acc = in_valid && m_in_ready();
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hold = 1;
                    m_res  = m_pill ? 32'd0 : fpu_fn(m_fsel, m_fd1, m_fd2, m_fd3);
                    m_rd   = m_tag;
                    m_ill  = m_pill;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 0;
            end
            if (acc) begin
                m_fsel = in_select; m_fd1 = in_data1; m_fd2 = in_data2; m_fd3 = in_data3;
                m_tag  = in_rd;
                m_pill = is_illegal(in_select);
                m_left = lat_of(in_select);
                last_acc = 1;
            end
        end
    endtask

    task automatic model_check();
        check_eq("in_ready", 32'(in_ready), 32'(m_in_ready()));
        check_eq("busy", 32'(busy), 32'(m_left != 0 || m_hold));
        check_eq("out_valid", 32'(out_valid), 32'(m_hold));
        check_eq("out_result", out_result, m_res);
        check_eq("out_rd", 32'(out_rd), 32'(m_rd));
        check_eq("out_illegal", 32'(out_illegal), 32'(m_ill));
        check_eq("fpu_select", 32'(fpu_select), 32'(m_fsel));
        check_eq("fpu_data1", fpu_data1, m_fd1);
        check_eq("fpu_data2", fpu_data2, m_fd2);
        check_eq("fpu_data3", fpu_data3, m_fd3);
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic issue(logic [4:0] s, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                         logic [4:0] rd);
        in_valid = 1; in_select = s; in_data1 = a; in_data2 = b; in_data3 = c; in_rd = rd;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) check_eq("accept_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_select = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0; in_rd = '0;
        model_reset();
        last_acc = 0;
        step();
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        step();
        rst = 0;

        // FADD 1.0 + 2.0
        out_ready = 1;
        issue(5'd1, 32'h3F800000, 32'h40000000, 32'd0, 5'd3);
        wait_valid(lat);
        check_eq("fadd_lat", 32'(lat), 32'd2);
        check_eq("fadd_res", out_result, 32'h40400000);
        step();

        // FDIV 6.0 / 2.0 with back-pressure
        out_ready = 0;
        issue(5'd4, 32'h40C00000, 32'h40000000, 32'd0, 5'd9);
        wait_valid(lat);
        check_eq("fdiv_lat", 32'(lat), 32'd6);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("fdiv_hold_valid", 32'(out_valid), 32'd1);
            check_eq("fdiv_hold_res", out_result, 32'h40400000);
            check_eq("fdiv_hold_rd", 32'(out_rd), 32'd9);
            check_eq("fdiv_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        step();
        check_eq("fdiv_release", 32'(out_valid), 32'd0);

        // Illegal op
        issue(5'd13, 32'h12345678, 32'h9ABCDEF0, 32'h1, 5'd7);
        wait_valid(lat);
        check_eq("ill_lat", 32'(lat), 32'd1);
        check_eq("ill_res", out_result, 32'd0);
        check_eq("ill_flag", 32'(out_illegal), 32'd1);
        check_eq("ill_rd", 32'(out_rd), 32'd7);
        step();

        // Back-to-back: FMUL then a compare, request held valid
        issue(5'd3, 32'h40000000, 32'h40400000, 32'd0, 5'd4);
        in_valid = 1; in_select = 5'd10; in_data1 = 32'h3F800000; in_data2 = 32'h3F800000;
        in_data3 = 32'd0; in_rd = 5'd5;
        wait_valid(lat);
        check_eq("fmul_lat", 32'(lat), 32'd3);
        check_eq("fmul_res", out_result, 32'h40C00000);
        step();
        check_eq("b2b_accept", 32'(last_acc), 32'd1);
        in_valid = 0;
        wait_valid(lat);
        check_eq("feq_lat", 32'(lat), 32'd1);
        check_eq("feq_res", out_result, 32'h00000001);
        check_eq("feq_rd", 32'(out_rd), 32'd5);
        step();

        // Flush during FMADD
        issue(5'd14, 32'h11111111, 32'h22222222, 32'h33333333, 5'd2);
        step();
        flush = 1;
        step();
        flush = 0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("flush_no_valid", 32'(out_valid), 32'd0);
        end
        issue(5'd2, 32'h40400000, 32'h3F800000, 32'd0, 5'd6);
        wait_valid(lat);
        check_eq("fsub_lat", 32'(lat), 32'd2);
        check_eq("fsub_res", out_result, 32'h40000000);
        step();

        // Asynchronous reset mid-EXEC of an FDIV
        out_ready = 0;
        issue(5'd4, 32'h40C00000, 32'h40000000, 32'd0, 5'd8);
        step();
        #2 rst = 1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_fsel", 32'(fpu_select), 32'd0);
        check_eq("arst_fd1", fpu_data1, 32'd0);
        check_eq("arst_res", out_result, 32'd0);
        check_eq("arst_rd", 32'(out_rd), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd1);
        model_reset();
        step();
        rst = 0;
        out_ready = 1;
        issue(5'd1, 32'h3F800000, 32'h40000000, 32'd0, 5'd1);
        wait_valid(lat);
        check_eq("post_rst_lat", 32'(lat), 32'd2);
        check_eq("post_rst_res", out_result, 32'h40400000);
        step();

        // Randomized traffic; requests are held until accepted
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || last_acc) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                in_select = 5'($urandom_range(0, 31));
                in_data1  = $urandom;
                in_data2  = (in_select == 5'd10 && $urandom_range(0, 1) == 1) ? in_data1
                                                                             : $urandom;
                in_data3  = $urandom;
                in_rd     = 5'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end

        flush = 0; in_valid = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
